// File: rtl/sequence_generator.sv
// Serial pattern transmitter: captures a PAT_W-bit pattern on start and shifts
// it out MSB-first, repeating it repeat_cnt+1 times with GAP_LEN idle cycles
// between repetitions. Every output is registered from the next-state values,
// so the first pattern bit appears in the cycle after start is sampled.
module sequence_generator #(
    parameter int PAT_W   = 4,
    parameter int GAP_LEN = 2,
    parameter int REP_W   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [REP_W-1:0] repeat_cnt,
    input  logic             idle_bit,
    output logic             o,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);
    localparam logic [3:0] GAP_TOP = (GAP_LEN > 0) ? 4'(GAP_LEN - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [3:0]         gap_cnt_q, gap_cnt_d;
    logic               o_q, o_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Next-state logic; outputs are derived from the state being entered so
    // they line up with that state once registered.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        rep_d     = rep_q;
        bit_idx_d = bit_idx_q;
        gap_cnt_d = gap_cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    pat_d     = pattern;
                    rep_d     = repeat_cnt;
                    bit_idx_d = IDX_TOP;
                    state_d   = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (bit_idx_q == '0) begin
                    if (rep_q != '0) begin
                        if (GAP_LEN > 0) begin
                            gap_cnt_d = GAP_TOP;
                            state_d   = GAP;
                        end else begin
                            rep_d     = rep_q - REP_W'(1);
                            bit_idx_d = IDX_TOP;
                        end
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    bit_idx_d = bit_idx_q - IDX_W'(1);
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (gap_cnt_q == 4'd0) begin
                    rep_d     = rep_q - REP_W'(1);
                    bit_idx_d = IDX_TOP;
                    state_d   = SHIFT;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        o_d     = (state_d == SHIFT) ? pat_d[bit_idx_d] : idle_bit;
        valid_d = (state_d == SHIFT);
        busy_d  = (state_d == SHIFT) || (state_d == GAP);
        done_d  = (state_d == DONE);
    end

    // State, counters, captured pattern and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            rep_q     <= '0;
            bit_idx_q <= '0;
            gap_cnt_q <= '0;
            o_q       <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            rep_q     <= rep_d;
            bit_idx_q <= bit_idx_d;
            gap_cnt_q <= gap_cnt_d;
            o_q       <= o_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o     = o_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: two instances (GAP_LEN=2 and GAP_LEN=0) share
// one set of inputs. A per-instance reference model expands each accepted
// start into a list of per-cycle line events and pushes the expected outputs
// into a scoreboard; a monitor pops and compares once per cycle.
module tb_sequence_generator;

    localparam int PW = 4;
    localparam int RW = 4;

    typedef struct packed {
        logic idl;
        logic b;
        logic v;
        logic bz;
        logic d;
    } step_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [PW-1:0] pattern;
    logic [RW-1:0] repeat_cnt;
    logic          idle_bit;

    int compared   = 0;
    int mismatched = 0;

    function automatic step_t mkStep(logic idl, logic b, logic v, logic bz, logic d);
        step_t s;
        s.idl = idl;
        s.b   = b;
        s.v   = v;
        s.bz  = bz;
        s.d   = d;
        return s;
    endfunction

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int GL = (g == 0) ? 2 : 0;

        logic        o, valid, busy, done;
        step_t       sched[$];
        logic [3:0]  sb[$];
        step_t       cur = 5'b10000;

        sequence_generator #(
            .PAT_W  (PW),
            .GAP_LEN(GL),
            .REP_W  (RW)
        ) dut (
            .clock     (clock),
            .reset     (reset),
            .start     (start),
            .abort     (abort),
            .pattern   (pattern),
            .repeat_cnt(repeat_cnt),
            .idle_bit  (idle_bit),
            .o         (o),
            .valid     (valid),
            .busy      (busy),
            .done      (done)
        );

        // Reference model: at each edge decide what the line shows next cycle
        // and push that expectation into the scoreboard.
        always @(posedge clock) begin
            step_t nxt;
            if (!reset) begin
                sched.delete();
                sb.delete();
                sb.push_back(4'b0000);
                cur = mkStep(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            end else begin
                if (cur.bz && abort) begin
                    sched.delete();
                    nxt = mkStep(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                end else if (!cur.bz && start) begin
                    sched.delete();
                    for (int r = 0; r <= int'(repeat_cnt); r++) begin
                        for (int k = PW - 1; k >= 0; k--)
                            sched.push_back(mkStep(1'b0, pattern[k], 1'b1, 1'b1, 1'b0));
                        if (r < int'(repeat_cnt))
                            for (int k = 0; k < GL; k++)
                                sched.push_back(mkStep(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
                    end
                    sched.push_back(mkStep(1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
                    nxt = sched.pop_front();
                end else if (sched.size() > 0) begin
                    nxt = sched.pop_front();
                end else begin
                    nxt = mkStep(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                end
                cur = nxt;
                sb.push_back({(nxt.idl ? idle_bit : nxt.b), nxt.v, nxt.bz, nxt.d});
            end
        end

        // Asynchronous reset: the current cycle must already show all zeros.
        always @(negedge reset) begin
            sched.delete();
            sb.delete();
            sb.push_back(4'b0000);
            cur = mkStep(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Monitor: compare the line and status flags mid-cycle.
        always @(negedge clock) begin
            logic [3:0] exp;
            logic [3:0] got;
            got = {o, valid, busy, done};
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL scoreboard_empty g%0d t=%0t: got {o,valid,busy,done}=%b, no expectation queued",
                         g, $time, got);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    mismatched++;
                    $display("[TB] FAIL outputs g%0d t=%0t: got {o,valid,busy,done}=%b expected %b",
                             g, $time, got, exp);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [PW-1:0] p, input logic [RW-1:0] r, input logic ib);
        @(negedge clock);
        pattern    = p;
        repeat_cnt = r;
        idle_bit   = ib;
        start      = 1'b1;
        @(negedge clock);
        start      = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Directed scenarios followed by randomized traffic.
    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        pattern    = '0;
        repeat_cnt = '0;
        idle_bit   = 1'b0;
        idleCycles(3);
        reset = 1'b1;
        idleCycles(2);

        applyStimulus(4'b1001, 4'd0, 1'b0);
        idleCycles(8);

        applyStimulus(4'b1101, 4'd2, 1'b1);
        idleCycles(20);

        applyStimulus(4'b0110, 4'd1, 1'b0);
        idleCycles(20);

        applyStimulus(4'b1001, 4'd0, 1'b0);
        pattern = 4'b1111;
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        idleCycles(8);

        @(negedge clock);
        pattern    = 4'b1001;
        repeat_cnt = 4'd0;
        start      = 1'b1;
        idleCycles(6);
        pattern    = 4'b0101;
        idleCycles(1);
        start      = 1'b0;
        idleCycles(10);

        applyStimulus(4'b1001, 4'd0, 1'b1);
        idleCycles(1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        idleCycles(8);

        applyStimulus(4'b1101, 4'd2, 1'b1);
        idleCycles(4);
        @(posedge clock);
        #2 reset = 1'b0;
        idleCycles(2);
        reset = 1'b1;
        idleCycles(2);
        applyStimulus(4'b1001, 4'd0, 1'b0);
        idleCycles(8);

        applyStimulus(4'b1010, 4'd15, 1'b0);
        idleCycles(PW * 16 + 2 * 15 + 6);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            start      = ($urandom_range(0, 5) == 0);
            abort      = ($urandom_range(0, 29) == 0);
            pattern    = PW'($urandom);
            repeat_cnt = ($urandom_range(0, 9) == 0) ? RW'($urandom) : RW'($urandom_range(0, 2));
            idle_bit   = 1'($urandom);
        end
        start = 1'b0;
        abort = 1'b0;
        idleCycles(120);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
